// File: rtl/lsq_dmem_arbiter_pkg.sv
// Shared LSU types for the store/load queue front end of the D-cache port.
package lsq_dmem_arbiter_pkg;

    localparam int LDQ_DEPTH        = 8;
    localparam int LDQ_TAG_W        = $clog2(LDQ_DEPTH);
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0]          addr;
        logic [3:0]           rmask;
        logic [3:0]           wmask;
        logic [31:0]          wdata;
        logic [LDQ_TAG_W-1:0] tag;
        logic                 is_load;
    } dmem_req_t;

endpackage

// File: rtl/lsq_dmem_arbiter_if.sv
// STQ/LDQ request channels, load response channel and the single D-cache port.
interface lsq_dmem_arbiter_if
    import lsq_dmem_arbiter_pkg::*;
;
    logic                 backend_flush;
    logic                 st_valid;
    logic                 st_ready;
    logic [31:0]          st_addr;
    logic [3:0]           st_wmask;
    logic [31:0]          st_wdata;
    logic                 ld_valid;
    logic                 ld_ready;
    logic [31:0]          ld_addr;
    logic [3:0]           ld_rmask;
    logic [LDQ_TAG_W-1:0] ld_tag;
    logic                 ld_resp_valid;
    logic [LDQ_TAG_W-1:0] ld_resp_tag;
    logic [31:0]          ld_resp_rdata;
    logic [31:0]          dc_addr;
    logic [3:0]           dc_rmask;
    logic [3:0]           dc_wmask;
    logic [31:0]          dc_wdata;
    logic                 dc_resp;
    logic [31:0]          dc_rdata;

    modport slave (
        input  backend_flush, st_valid, st_addr, st_wmask, st_wdata,
               ld_valid, ld_addr, ld_rmask, ld_tag, dc_resp, dc_rdata,
        output st_ready, ld_ready, ld_resp_valid, ld_resp_tag, ld_resp_rdata,
               dc_addr, dc_rmask, dc_wmask, dc_wdata
    );

    modport master (
        output backend_flush, st_valid, st_addr, st_wmask, st_wdata,
               ld_valid, ld_addr, ld_rmask, ld_tag, dc_resp, dc_rdata,
        input  st_ready, ld_ready, ld_resp_valid, ld_resp_tag, ld_resp_rdata,
               dc_addr, dc_rmask, dc_wmask, dc_wdata
    );

endinterface

// File: rtl/lsq_arb_select.sv
// Store-first pick between the STQ head and the LDQ, with a forced load once
// the starvation limit is reached. Flush blocks only the load side.
module lsq_arb_select (
    input  logic idle,
    input  logic st_valid,
    input  logic ld_valid,
    input  logic flush,
    input  logic starve_hit,
    output logic st_grant,
    output logic ld_grant
);

    always_comb begin
        ld_grant = idle && ld_valid && !flush && (!st_valid || starve_hit);
        st_grant = idle && st_valid && !ld_grant;
    end

endmodule

// File: rtl/lsq_dmem_arbiter.sv
// Single-port D-cache front end: one registered access outstanding at a time,
// load responses routed back by tag and squashed when their epoch was flushed.
module lsq_dmem_arbiter
    import lsq_dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    lsq_dmem_arbiter_if.slave   bus
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state, state_nxt;
    dmem_req_t        req;
    logic [CNT_W-1:0] starve_cnt;
    logic             drop;
    logic             stray_ok;
    logic             idle;
    logic             st_grant, ld_grant;
    logic             resp_hit;

    assign idle = (state == S_IDLE) && !rst;

    lsq_arb_select u_select (
        .idle       (idle),
        .st_valid   (bus.st_valid),
        .ld_valid   (bus.ld_valid),
        .flush      (bus.backend_flush),
        .starve_hit (starve_cnt == CNT_MAX),
        .st_grant   (st_grant),
        .ld_grant   (ld_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req        <= '0;
            starve_cnt <= '0;
            drop       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (st_grant)
                req <= '{addr: bus.st_addr, rmask: 4'h0, wmask: bus.st_wmask,
                         wdata: bus.st_wdata, tag: '0, is_load: 1'b0};
            else if (ld_grant)
                req <= '{addr: bus.ld_addr, rmask: bus.ld_rmask, wmask: 4'h0,
                         wdata: 32'h0, tag: bus.ld_tag, is_load: 1'b1};

            if (ld_grant || !bus.ld_valid)
                starve_cnt <= '0;
            else if (st_grant && starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + 1'b1;

            if (state == S_WAIT && bus.dc_resp)
                drop <= 1'b0;
            else if (state != S_IDLE && req.is_load && bus.backend_flush)
                drop <= 1'b1;
        end
    end

    // A reset that cuts an access short may still see that access's response
    // arrive later; remember this so the protocol check tolerates it once.
    always_ff @(posedge clk) begin
        if (rst)
            stray_ok <= stray_ok || (state != S_IDLE);
        else if (bus.dc_resp || st_grant || ld_grant)
            stray_ok <= 1'b0;
    end

    always_comb begin
        state_nxt         = state;
        resp_hit          = 1'b0;
        bus.st_ready      = st_grant;
        bus.ld_ready      = ld_grant;
        bus.dc_addr       = req.addr;
        bus.dc_wdata      = req.wdata;
        bus.dc_rmask      = 4'h0;
        bus.dc_wmask      = 4'h0;
        bus.ld_resp_valid = 1'b0;
        bus.ld_resp_tag   = '0;
        bus.ld_resp_rdata = 32'h0;

        unique case (state)
            S_IDLE: begin
                if (st_grant || ld_grant)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
                if (req.is_load)
                    bus.dc_rmask = req.rmask;
                else
                    bus.dc_wmask = req.wmask;
            end
            S_WAIT: begin
                if (bus.dc_resp)
                    state_nxt = S_IDLE;
                resp_hit = !rst && bus.dc_resp && req.is_load && !drop && !bus.backend_flush;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (resp_hit) begin
            bus.ld_resp_valid = 1'b1;
            bus.ld_resp_tag   = req.tag;
            bus.ld_resp_rdata = bus.dc_rdata;
        end
    end

    a_resp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
        bus.dc_resp |-> (state == S_WAIT) || (state == S_IDLE && stray_ok));

endmodule

// File: tb/tb_lsq_dmem_arbiter.sv
// Bench for lsq_dmem_arbiter: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a transaction-level model.
module tb_lsq_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsq_dmem_arbiter_if bus ();

    lsq_dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        st_valid, ld_valid, flush, dc_resp;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [2:0]  tag;
        logic        e_st, e_ld;
        logic [3:0]  e_wm, e_rm;
        logic        e_resp;
        logic [2:0]  e_tag;
        logic [31:0] e_rdata;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic inputs_zero();
        bus.backend_flush = 1'b0;
        bus.st_valid      = 1'b0;
        bus.st_addr       = 32'h0;
        bus.st_wmask      = 4'h0;
        bus.st_wdata      = 32'h0;
        bus.ld_valid      = 1'b0;
        bus.ld_addr       = 32'h0;
        bus.ld_rmask      = 4'h0;
        bus.ld_tag        = 3'd0;
        bus.dc_resp       = 1'b0;
        bus.dc_rdata      = 32'h0;
    endtask

    task automatic check_all_zero(input string tagname);
        check({tagname, "_st_ready"}, bus.st_ready, 0);
        check({tagname, "_ld_ready"}, bus.ld_ready, 0);
        check({tagname, "_dc_addr"},  bus.dc_addr, 0);
        check({tagname, "_dc_rmask"}, bus.dc_rmask, 0);
        check({tagname, "_dc_wmask"}, bus.dc_wmask, 0);
        check({tagname, "_dc_wdata"}, bus.dc_wdata, 0);
        check({tagname, "_resp"},     bus.ld_resp_valid, 0);
    endtask

    // One complete load access, responding two cycles after ISSUE.
    task automatic do_load(input logic [2:0] tag, input logic [31:0] addr, input logic [31:0] data,
                           input bit fl_wait, input bit fl_resp, input bit exp_resp);
        inputs_zero();
        bus.ld_valid = 1'b1; bus.ld_addr = addr; bus.ld_rmask = 4'hF; bus.ld_tag = tag;
        #1;
        check("load_grant", bus.ld_ready, 1);
        next_cycle();
        inputs_zero();
        #1;
        check("load_issue_rmask", bus.dc_rmask, 4'hF);
        check("load_issue_addr", bus.dc_addr, addr);
        next_cycle();
        inputs_zero();
        bus.backend_flush = fl_wait;
        #1;
        check("load_wait_no_resp", bus.ld_resp_valid, 0);
        next_cycle();
        inputs_zero();
        bus.dc_resp = 1'b1; bus.dc_rdata = data; bus.backend_flush = fl_resp;
        #1;
        check("load_resp_valid", bus.ld_resp_valid, exp_resp);
        if (exp_resp) begin
            check("load_resp_tag", bus.ld_resp_tag, tag);
            check("load_resp_rdata", bus.ld_resp_rdata, data);
        end
        next_cycle();
        inputs_zero();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int age, g, wm_cnt, busy_rdy;
        bit gl [10];

        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0, 32'h100, 4'hF, 32'hDEADBEEF, 3'd0, 1'b1,1'b0, 4'h0,4'h0, 1'b0,3'd0,32'h0, 32'h0};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   4'h0, 32'h0,        3'd0, 1'b0,1'b0, 4'hF,4'h0, 1'b0,3'd0,32'h0, 32'h100};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   4'h0, 32'h0,        3'd0, 1'b0,1'b0, 4'h0,4'h0, 1'b0,3'd0,32'h0, 32'h100};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b1, 32'h0,   4'h0, 32'h0,        3'd0, 1'b0,1'b0, 4'h0,4'h0, 1'b0,3'd0,32'h0, 32'h100};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b0, 32'h200, 4'h3, 32'h0,        3'd5, 1'b0,1'b1, 4'h0,4'h0, 1'b0,3'd0,32'h0, 32'h100};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   4'h0, 32'h0,        3'd0, 1'b0,1'b0, 4'h0,4'h3, 1'b0,3'd0,32'h0, 32'h200};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   4'h0, 32'h0,        3'd0, 1'b0,1'b0, 4'h0,4'h0, 1'b0,3'd0,32'h0, 32'h200};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b1, 32'h0,   4'h0, 32'h1234,     3'd0, 1'b0,1'b0, 4'h0,4'h0, 1'b1,3'd5,32'h1234, 32'h200};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   4'h0, 32'h0,        3'd0, 1'b0,1'b0, 4'h0,4'h0, 1'b0,3'd0,32'h0, 32'h200};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b0, 32'h300, 4'hF, 32'hA5A5A5A5, 3'd1, 1'b1,1'b0, 4'h0,4'h0, 1'b0,3'd0,32'h0, 32'h200};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   4'h0, 32'h0,        3'd0, 1'b0,1'b0, 4'hF,4'h0, 1'b0,3'd0,32'h0, 32'h300};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   4'h0, 32'h0,        3'd0, 1'b0,1'b0, 4'h0,4'h0, 1'b0,3'd0,32'h0, 32'h300};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b1, 32'h0,   4'h0, 32'hFFFF0000, 3'd0, 1'b0,1'b0, 4'h0,4'h0, 1'b0,3'd0,32'h0, 32'h300};

        inputs_zero();
        rst = 1'b1;
        repeat (3) next_cycle();
        rst = 1'b0;
        #1;
        check_all_zero("reset");
        next_cycle();

        // Store-only access, then load-only access, then store-over-load default.
        for (int i = 0; i < 13; i++) begin
            bus.st_valid = tbl[i].st_valid; bus.ld_valid = tbl[i].ld_valid;
            bus.backend_flush = tbl[i].flush; bus.dc_resp = tbl[i].dc_resp;
            bus.st_addr = tbl[i].addr; bus.ld_addr = tbl[i].addr;
            bus.st_wmask = tbl[i].mask; bus.ld_rmask = tbl[i].mask;
            bus.st_wdata = tbl[i].data; bus.dc_rdata = tbl[i].data;
            bus.ld_tag = tbl[i].tag;
            #1;
            check($sformatf("vec%0d_st_ready", i), bus.st_ready, tbl[i].e_st);
            check($sformatf("vec%0d_ld_ready", i), bus.ld_ready, tbl[i].e_ld);
            check($sformatf("vec%0d_dc_wmask", i), bus.dc_wmask, tbl[i].e_wm);
            check($sformatf("vec%0d_dc_rmask", i), bus.dc_rmask, tbl[i].e_rm);
            check($sformatf("vec%0d_dc_addr", i), bus.dc_addr, tbl[i].e_addr);
            check($sformatf("vec%0d_resp", i), bus.ld_resp_valid, tbl[i].e_resp);
            if (tbl[i].e_resp) begin
                check($sformatf("vec%0d_resp_tag", i), bus.ld_resp_tag, tbl[i].e_tag);
                check($sformatf("vec%0d_resp_rdata", i), bus.ld_resp_rdata, tbl[i].e_rdata);
            end
            if (tbl[i].e_wm != 4'h0)
                check($sformatf("vec%0d_dc_wdata", i), bus.dc_wdata, 32'hDEADBEEF ^ ((i == 10) ? 32'h7B081B4A : 32'h0));
            next_cycle();
        end
        inputs_zero();

        // Contention: both queues always valid -> four stores, one load, repeat.
        age = 0; g = 0;
        for (int c = 0; c < 80 && g < 10; c++) begin
            bus.st_valid = 1'b1; bus.ld_valid = 1'b1;
            bus.st_addr = 32'h40 + 32'(c * 4); bus.st_wmask = 4'hF; bus.st_wdata = 32'(c);
            bus.ld_addr = 32'h80; bus.ld_rmask = 4'hF; bus.ld_tag = 3'd1;
            bus.dc_resp = (age == 2);
            #1;
            if (bus.st_ready || bus.ld_ready) begin
                gl[g] = bus.ld_ready;
                g++;
            end
            if (bus.dc_resp) age = 0;
            else if (bus.st_ready || bus.ld_ready) age = 1;
            else if (age != 0) age++;
            next_cycle();
        end
        check("contention_grant_count", g, 10);
        for (int i = 0; i < g; i++)
            check($sformatf("contention_grant%0d_is_load", i), gl[i], (i % 5 == 4));
        inputs_zero();
        for (int c = 0; c < 3; c++) begin
            bus.dc_resp = (age == 2);
            #1;
            if (bus.dc_resp) age = 0; else if (age != 0) age++;
            next_cycle();
        end
        inputs_zero();

        // Flush while a load waits: response squashed, next loads behave normally.
        do_load(3'd2, 32'h400, 32'hBAD0BAD0, 1'b1, 1'b0, 1'b0);
        bus.ld_valid = 1'b1; bus.backend_flush = 1'b1; bus.ld_rmask = 4'hF;
        #1;
        check("flush_idle_ld_ready", bus.ld_ready, 0);
        next_cycle();
        inputs_zero();
        do_load(3'd3, 32'h404, 32'h13579BDF, 1'b0, 1'b0, 1'b1);
        do_load(3'd6, 32'h408, 32'h2468ACE0, 1'b0, 1'b1, 1'b0);
        do_load(3'd7, 32'h40C, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b1);

        // Flush while a store is in flight: write still completes exactly once.
        inputs_zero();
        bus.st_valid = 1'b1; bus.st_addr = 32'h500; bus.st_wmask = 4'hC; bus.st_wdata = 32'h0BADF00D;
        bus.backend_flush = 1'b1;
        #1;
        check("flush_store_grant", bus.st_ready, 1);
        next_cycle();
        wm_cnt = 0; busy_rdy = 0;
        for (int c = 0; c < 4; c++) begin
            bus.backend_flush = (c == 1);
            bus.dc_resp = (c == 3);
            #1;
            if (bus.dc_wmask != 4'h0) wm_cnt++;
            if (bus.st_ready) busy_rdy++;
            if (c == 0) check("flush_store_wdata", bus.dc_wdata, 32'h0BADF00D);
            next_cycle();
        end
        check("flush_store_wmask_cycles", wm_cnt, 1);
        check("flush_store_ready_while_busy", busy_rdy, 0);
        bus.dc_resp = 1'b0; bus.backend_flush = 1'b0;
        #1;
        check("flush_store_next_grant", bus.st_ready, 1);
        next_cycle();
        inputs_zero();
        next_cycle();
        bus.dc_resp = 1'b1;
        #1;
        next_cycle();
        inputs_zero();

        // Reset during ISSUE of a load, then a stray response while idle.
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h600; bus.ld_rmask = 4'hF; bus.ld_tag = 3'd4;
        #1;
        check("rst_ld_grant", bus.ld_ready, 1);
        next_cycle();
        inputs_zero();
        rst = 1'b1;
        #1;
        check("rst_issue_rmask", bus.dc_rmask, 4'hF);
        next_cycle();
        rst = 1'b0;
        #1;
        check_all_zero("after_rst");
        next_cycle();
        bus.dc_resp = 1'b1; bus.dc_rdata = 32'h77;
        #1;
        check("stray_resp_valid", bus.ld_resp_valid, 0);
        next_cycle();
        inputs_zero();

        // Randomized traffic against a transaction-level model.
        begin
            bit          busy = 1'b0, m_load = 1'b0, m_drop = 1'b0;
            int          m_age = 0, streak = 0;
            logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
            logic [3:0]  m_mask = 4'h0;
            logic [2:0]  m_tag = 3'd0;
            bit          ld_win, st_win, e_resp;
            for (int c = 0; c < 3000; c++) begin
                bus.st_valid = ($urandom_range(0, 3) != 0);
                bus.ld_valid = ($urandom_range(0, 2) != 0);
                bus.backend_flush = ($urandom_range(0, 9) == 0);
                bus.st_addr = $urandom & 32'hFFFF_FFFC;
                bus.ld_addr = $urandom & 32'hFFFF_FFFC;
                bus.st_wmask = 4'($urandom_range(1, 15));
                bus.ld_rmask = 4'($urandom_range(1, 15));
                bus.st_wdata = $urandom;
                bus.ld_tag = 3'($urandom_range(0, 7));
                bus.dc_resp = busy && (m_age >= 2) && ($urandom_range(0, 2) == 0);
                bus.dc_rdata = $urandom;

                ld_win = !busy && bus.ld_valid && !bus.backend_flush && (!bus.st_valid || streak >= 4);
                st_win = !busy && bus.st_valid && !ld_win;
                e_resp = busy && (m_age >= 2) && bus.dc_resp && m_load && !m_drop && !bus.backend_flush;
                #1;
                check("rnd_st_ready", bus.st_ready, st_win);
                check("rnd_ld_ready", bus.ld_ready, ld_win);
                check("rnd_dc_wmask", bus.dc_wmask, (busy && m_age == 1 && !m_load) ? m_mask : 4'h0);
                check("rnd_dc_rmask", bus.dc_rmask, (busy && m_age == 1 && m_load) ? m_mask : 4'h0);
                check("rnd_dc_addr", bus.dc_addr, m_addr);
                check("rnd_resp_valid", bus.ld_resp_valid, e_resp);
                if (e_resp) begin
                    check("rnd_resp_tag", bus.ld_resp_tag, m_tag);
                    check("rnd_resp_rdata", bus.ld_resp_rdata, bus.dc_rdata);
                end
                if (busy && m_age == 1 && !m_load)
                    check("rnd_dc_wdata", bus.dc_wdata, m_wdata);

                if (busy && m_load && bus.backend_flush) m_drop = 1'b1;
                if (busy && m_age >= 2 && bus.dc_resp) busy = 1'b0;
                else if (busy) m_age++;
                if (st_win || ld_win) begin
                    busy = 1'b1; m_age = 1; m_drop = 1'b0; m_load = ld_win;
                    m_addr = ld_win ? bus.ld_addr : bus.st_addr;
                    m_mask = ld_win ? bus.ld_rmask : bus.st_wmask;
                    m_wdata = ld_win ? 32'h0 : bus.st_wdata;
                    m_tag = bus.ld_tag;
                end
                if (!bus.ld_valid || ld_win) streak = 0;
                else if (st_win && streak < 4) streak++;
                next_cycle();
            end
        end

        inputs_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
